// File: rtl/mem_multiport_pkg.sv
// Shared types and helpers for the multi-read-port memory.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN
  } mem_state_t;

  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_multiport_if.sv
// Bus bundle for mem_multiport: NUM_RD packed read ports plus one write port.
interface mem_multiport_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NUM_RD = 2
);

  logic                       ready;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic [NUM_RD-1:0]          rd_err;
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic                       wr_err;

  modport master (
    input  ready, rd_data, rd_valid, rd_err, wr_err,
    output rd_en, rd_addr, we, waddr, wdata
  );

  modport slave (
    output ready, rd_data, rd_valid, rd_err, wr_err,
    input  rd_en, rd_addr, we, waddr, wdata
  );

endinterface

// File: rtl/mem_multiport_rd_port.sv
// One read port: stage 1 captures the request, stage 2 registers array data,
// range error or a same-cycle write forwarded ahead of the array.
module mem_rd_port
  import mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [ADDR_W-1:0] s1_addr_o,
  input  logic [DATA_W-1:0] mem_word_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_err_o
);

  logic              s1Valid_q;
  logic [ADDR_W-1:0] s1Addr_q;
  logic              valid_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              inRange;

  assign inRange = addr_in_range(64'(s1Addr_q), 64'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1Addr_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      s1Valid_q <= req_i;
      s1Addr_q  <= addr_i;
      valid_q   <= s1Valid_q;
      err_q     <= s1Valid_q && !inRange;
      data_q    <= data_d;
    end
  end

  // Write-first: a write landing on the stage-2 edge wins over the stale array word.
  always_comb begin
    data_d = data_q;
    if (s1Valid_q) begin
      if (!inRange) begin
        data_d = '0;
      end else if (wr_fire_i && (waddr_i == s1Addr_q)) begin
        data_d = wdata_i;
      end else begin
        data_d = mem_word_i;
      end
    end
  end

  assign s1_addr_o  = s1Addr_q;
  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign rd_err_o   = err_q;

endmodule

// File: rtl/mem_multiport.sv
// Multi-read-port, single-write-port synchronous memory with 2-cycle read
// latency, write forwarding, range checking and an optional post-reset clear.
module mem_multiport
  import mem_pkg::*;
#(
  parameter int              DATA_W         = 16,
  parameter int              ADDR_W         = 16,
  parameter int              DEPTH          = 1024,
  parameter int              NUM_RD         = 2,
  parameter bit              CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  mem_multiport_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  mem_state_t        state_q, state_d;
  logic [IDX_W-1:0]  clrCnt_q, clrCnt_d;
  logic              wrErr_q;
  logic              ready;
  logic              wrInRange;
  logic              wrFire;
  logic              memWe;
  logic [IDX_W-1:0]  memIdx;
  logic [DATA_W-1:0] memWdata;

  logic [ADDR_W-1:0] s1Addr   [NUM_RD];
  logic [DATA_W-1:0] memWord  [NUM_RD];
  logic [DATA_W-1:0] rdData   [NUM_RD];
  logic              rdValid  [NUM_RD];
  logic              rdErr    [NUM_RD];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      clrCnt_q <= '0;
      wrErr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
      wrErr_q  <= ready && bus.we && !wrInRange;
    end
  end

  // Without a clear sweep the memory is usable straight out of reset, IDLE included.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready    = !CLEAR_ON_RESET;
        clrCnt_d = '0;
        state_d  = CLEAR_ON_RESET ? CLEAR : RUN;
      end
      CLEAR: begin
        if (clrCnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          clrCnt_d = clrCnt_q + 1'b1;
        end
      end
      RUN: ready = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign wrInRange = addr_in_range(64'(bus.waddr), 64'(DEPTH));
  assign wrFire    = ready && bus.we && wrInRange;

  always_comb begin
    memWe    = wrFire;
    memIdx   = IDX_W'(bus.waddr);
    memWdata = bus.wdata;
    if (state_q == CLEAR) begin
      memWe    = 1'b1;
      memIdx   = clrCnt_q;
      memWdata = INIT_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memIdx] <= memWdata;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign memWord[p] = mem[IDX_W'(s1Addr[p])];

    mem_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .clk        (clk),
      .reset      (reset),
      .req_i      (ready && bus.rd_en[p]),
      .addr_i     (bus.rd_addr[p*ADDR_W +: ADDR_W]),
      .wr_fire_i  (wrFire),
      .waddr_i    (bus.waddr),
      .wdata_i    (bus.wdata),
      .s1_addr_o  (s1Addr[p]),
      .mem_word_i (memWord[p]),
      .rd_data_o  (rdData[p]),
      .rd_valid_o (rdValid[p]),
      .rd_err_o   (rdErr[p])
    );
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_valid = '0;
    bus.rd_err   = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      bus.rd_data[p*DATA_W +: DATA_W] = rdData[p];
      bus.rd_valid[p]                 = rdValid[p];
      bus.rd_err[p]                   = rdErr[p];
    end
  end

  assign bus.ready  = ready;
  assign bus.wr_err = wrErr_q;

endmodule

// File: tb/tb_mem_multiport.sv
// Directed self-checking bench: instance A (1024 words, 4 ports, no clear)
// and instance B (16 words, 2 ports, clear sweep to 0xA5A5).
module tb_mem_multiport;

  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic resetA;
  logic resetB;
  int   total = 0;
  int   bad   = 0;

  logic [3:0]  expErr;
  logic [63:0] expData;
  logic [15:0] a;

  mem_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4)) busA ();
  mem_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) busB ();

  mem_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .NUM_RD(4),
    .CLEAR_ON_RESET(1'b0), .INIT_VALUE(16'h0000)
  ) dutA (
    .clk   (clk),
    .reset (resetA),
    .bus   (busA.slave)
  );

  mem_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .NUM_RD(2),
    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'hA5A5)
  ) dutB (
    .clk   (clk),
    .reset (resetB),
    .bus   (busB.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive instance A for the next edge, then advance to the following negedge.
  task automatic applyStimulus(input logic [3:0] en, input logic [63:0] addrs,
                               input logic w, input logic [15:0] wa,
                               input logic [15:0] wd);
    busA.rd_en   = en;
    busA.rd_addr = addrs;
    busA.we      = w;
    busA.waddr   = wa;
    busA.wdata   = wd;
    @(negedge clk);
  endtask

  function automatic logic [15:0] mpAddr(input int c, input int p);
    if (c == 2) return 16'h0003;
    if (c == 4 && p == 3) return 16'h0401;
    return 16'((c * 3 + p) % 8);
  endfunction

  function automatic logic [15:0] expWord(input logic [15:0] ad);
    if (ad >= 16'h0400) return 16'h0000;
    return 16'h1000 + ad * 16'h0011;
  endfunction

  initial begin
    resetA = 1'b0;
    resetB = 1'b0;
    busA.rd_en = '0; busA.rd_addr = '0; busA.we = 1'b0; busA.waddr = '0; busA.wdata = '0;
    busB.rd_en = '0; busB.rd_addr = '0; busB.we = 1'b0; busB.waddr = '0; busB.wdata = '0;
    #1;
    resetA = 1'b1;
    resetB = 1'b1;
    #1;
    checkOutput("rstA_ready", 64'(busA.ready), 64'd1);
    checkOutput("rstA_valid", 64'(busA.rd_valid), 64'd0);
    checkOutput("rstA_err", 64'(busA.rd_err), 64'd0);
    checkOutput("rstA_data", 64'(busA.rd_data), 64'd0);
    checkOutput("rstA_werr", 64'(busA.wr_err), 64'd0);
    checkOutput("rstB_ready", 64'(busB.ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetA = 1'b0;

    // Latency: write mem[5], read it on port 0
    applyStimulus(4'd0, 64'd0, 1'b1, 16'h0005, 16'hBEEF);
    applyStimulus(4'b0001, 64'h0000_0000_0000_0005, 1'b0, 16'h0, 16'h0);
    checkOutput("lat_early", 64'(busA.rd_valid), 64'd0);
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("lat_valid", 64'(busA.rd_valid), 64'b0001);
    checkOutput("lat_data", 64'(busA.rd_data[15:0]), 64'hBEEF);
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("lat_once", 64'(busA.rd_valid), 64'd0);
    checkOutput("lat_hold", 64'(busA.rd_data[15:0]), 64'hBEEF);

    // Forwarding: write at T+1 forwarded to port 1, unrelated port 0 unaffected
    applyStimulus(4'd0, 64'd0, 1'b1, 16'h0007, 16'h1111);
    applyStimulus(4'b0011, 64'h0000_0000_0007_0005, 1'b0, 16'h0, 16'h0);
    applyStimulus(4'd0, 64'd0, 1'b1, 16'h0007, 16'h1234);
    checkOutput("fwd_valid", 64'(busA.rd_valid), 64'b0011);
    checkOutput("fwd_data", 64'(busA.rd_data[31:16]), 64'h1234);
    checkOutput("fwd_nomatch", 64'(busA.rd_data[15:0]), 64'hBEEF);
    applyStimulus(4'b0010, 64'h0000_0000_0007_0000, 1'b0, 16'h0, 16'h0);
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("late_w_data", 64'(busA.rd_data[31:16]), 64'h1234);
    applyStimulus(4'd0, 64'd0, 1'b1, 16'h0007, 16'h5678);
    checkOutput("late_w_valid", 64'(busA.rd_valid), 64'd0);
    applyStimulus(4'b0010, 64'h0000_0000_0007_0000, 1'b0, 16'h0, 16'h0);
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("late_w_stored", 64'(busA.rd_data[31:16]), 64'h5678);

    // Range: last legal word, out-of-range write and read
    applyStimulus(4'd0, 64'd0, 1'b1, 16'h0000, 16'h00AA);
    applyStimulus(4'd0, 64'd0, 1'b1, 16'h03FF, 16'h3FF3);
    checkOutput("inrange_werr", 64'(busA.wr_err), 64'd0);
    applyStimulus(4'd0, 64'd0, 1'b1, 16'h0400, 16'hDEAD);
    checkOutput("oor_werr", 64'(busA.wr_err), 64'd1);
    applyStimulus(4'b1100, 64'h0400_03FF_0000_0000, 1'b0, 16'h0, 16'h0);
    checkOutput("oor_werr_pulse", 64'(busA.wr_err), 64'd0);
    applyStimulus(4'b0100, 64'h0000_0000_0000_0000, 1'b0, 16'h0, 16'h0);
    checkOutput("oor_valid", 64'(busA.rd_valid), 64'b1100);
    checkOutput("oor_err", 64'(busA.rd_err), 64'b1000);
    checkOutput("oor_data", 64'(busA.rd_data[63:32]), 64'h0000_3FF3);
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("oor_w_dropped", 64'(busA.rd_data[47:32]), 64'h00AA);
    checkOutput("oor_err_clear", 64'(busA.rd_err), 64'd0);

    // Multi-port: fill words 0..7, then back-to-back reads on all four ports
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'd0, 64'd0, 1'b1, 16'(i), 16'h1000 + 16'(i) * 16'h0011);
    end
    for (int c = 0; c < 7; c++) begin
      if (c < 6) begin
        applyStimulus(4'hF, {mpAddr(c, 3), mpAddr(c, 2), mpAddr(c, 1), mpAddr(c, 0)},
                      1'b0, 16'h0, 16'h0);
      end else begin
        applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
      end
      if (c >= 1) begin
        for (int p = 0; p < 4; p++) begin
          a = mpAddr(c - 1, p);
          expErr[p] = (a >= 16'h0400);
          expData[p*16 +: 16] = expWord(a);
        end
        checkOutput("mp_valid", 64'(busA.rd_valid), 64'hF);
        checkOutput("mp_err", 64'(busA.rd_err), 64'(expErr));
        checkOutput("mp_data", busA.rd_data, expData);
      end
    end
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("mp_drain", 64'(busA.rd_valid), 64'd0);

    // Reset with reads in flight
    applyStimulus(4'hF, {4{16'h0001}}, 1'b0, 16'h0, 16'h0);
    applyStimulus(4'hF, {4{16'h0002}}, 1'b0, 16'h0, 16'h0);
    checkOutput("pre_rst_valid", 64'(busA.rd_valid), 64'hF);
    resetA = 1'b1;
    #1;
    checkOutput("rst_valid_now", 64'(busA.rd_valid), 64'd0);
    checkOutput("rst_data_now", busA.rd_data, 64'd0);
    busA.rd_en = '0;
    @(negedge clk);
    resetA = 1'b0;
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("post_rst_quiet1", 64'(busA.rd_valid), 64'd0);
    applyStimulus(4'd0, 64'd0, 1'b0, 16'h0, 16'h0);
    checkOutput("post_rst_quiet2", 64'(busA.rd_valid), 64'd0);

    // Clear sweep on B: requests ignored while ready is low
    busB.rd_en   = 2'b11;
    busB.rd_addr = {16'h0003, 16'h0002};
    busB.we      = 1'b1;
    busB.waddr   = 16'h0002;
    busB.wdata   = 16'h1111;
    resetB = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checkOutput("clr_quiet", {58'd0, busB.ready, busB.rd_valid, busB.rd_err, busB.wr_err}, 64'd0);
    end
    busB.rd_en = '0;
    busB.we    = 1'b0;
    @(negedge clk);
    checkOutput("clr_ready", 64'(busB.ready), 64'd1);
    checkOutput("clr_no_valid", 64'(busB.rd_valid), 64'd0);
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        busB.rd_en   = 2'b11;
        busB.rd_addr = {16'(2 * c + 1), 16'(2 * c)};
      end else if (c == 8) begin
        busB.rd_en   = 2'b11;
        busB.rd_addr = {16'h0010, 16'h000F};
      end else begin
        busB.rd_en   = 2'b00;
      end
      @(negedge clk);
      if (c == 0) begin
        checkOutput("clr_no_leak", 64'(busB.rd_valid), 64'd0);
      end else if (c < 9) begin
        checkOutput("clr_valid", 64'(busB.rd_valid), 64'b11);
        checkOutput("clr_data", 64'(busB.rd_data), 64'hA5A5_A5A5);
      end else begin
        checkOutput("b_edge_valid", 64'(busB.rd_valid), 64'b11);
        checkOutput("b_edge_err", 64'(busB.rd_err), 64'b10);
        checkOutput("b_edge_data", 64'(busB.rd_data), 64'h0000_A5A5);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
